tx_arbiter: RTL and testbench

Shares the single serial transmitter (Messenger byte port: `txData`/`txSend`/`txReady`) between two byte-stream requesters, e.g. TitleDrawer and the game-state/score reporter. Each requester hands over one byte at a time with a REQ/ACK handshake. The arbiter grants whole packets (bytes up to and including one flagged LAST) round-robin, and drives the Messenger with a level handshake that tolerates Messenger running on the slower BCLK. A timeout aborts a byte the transmitter never accepts.

---
 rtl/tx_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_tx_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one serial transmitter byte port between two byte-stream
// requesters. Whole packets (bytes up to and including one flagged LAST) are
// granted round-robin; each byte uses a REQ/ACK handshake on the requester side
// and a level SEND/READY handshake on the transmitter side. A byte that the
// transmitter never accepts is aborted after ACCEPT_TIMEOUT cycles in SEND.
//
// Ports:
//   CLK, RESET           clock, synchronous active-high reset
//   IN_REQ0/1            requester has a byte presented
//   IN_DATA0/1[7:0]      requester byte
//   IN_LAST0/1           byte is the last of its packet
//   OUT_ACK0/1           one-cycle pulse: byte latched
//   OUT_TX_DATA[7:0]     byte to transmitter (held until next selection)
//   OUT_TX_SEND          transmit request level
//   IN_TX_READY          transmitter idle (1) / busy (0)
//   OUT_GRANT[1:0]       one-hot packet owner, 00 when no packet is open
//   OUT_BUSY             arbiter not in IDLE
//   OUT_ERROR            one-cycle pulse on timeout abort
// All outputs are registered.

module tx_arbiter #(
    parameter int unsigned ACCEPT_TIMEOUT = 65535
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IN_REQ0,
    input  logic [7:0] IN_DATA0,
    input  logic       IN_LAST0,
    output logic       OUT_ACK0,
    input  logic       IN_REQ1,
    input  logic [7:0] IN_DATA1,
    input  logic       IN_LAST1,
    output logic       OUT_ACK1,
    output logic [7:0] OUT_TX_DATA,
    output logic       OUT_TX_SEND,
    input  logic       IN_TX_READY,
    output logic [1:0] OUT_GRANT,
    output logic       OUT_BUSY,
    output logic       OUT_ERROR
);

    localparam int unsigned TMO_W  = 16;
    localparam int unsigned DATA_W = 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACCEPT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // Registered state
    state_t              r_state;
    logic                r_lock;
    logic                r_owner;
    logic                r_last_served;
    logic                r_is_last;
    logic [TMO_W-1:0]    r_tmo;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_tx_send;
    logic                r_ack0;
    logic                r_ack1;
    logic [1:0]          r_grant;
    logic                r_busy;
    logic                r_error;

    // Next-state values
    state_t              w_state_nxt;
    logic                w_lock_nxt;
    logic                w_owner_nxt;
    logic                w_last_served_nxt;
    logic                w_is_last_nxt;
    logic [TMO_W-1:0]    w_tmo_nxt;
    logic [DATA_W-1:0]   w_tx_data_nxt;
    logic                w_tx_send_nxt;
    logic                w_ack0_nxt;
    logic                w_ack1_nxt;
    logic [1:0]          w_grant_nxt;
    logic                w_busy_nxt;
    logic                w_error_nxt;

    // Candidate selection
    logic                w_sel_valid;
    logic                w_sel_idx;

    // Candidate selection: locked packets only consider the owner; otherwise
    // round-robin on contention, favouring the requester not served last.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = 1'b0;
        if (r_lock) begin
            w_sel_valid = r_owner ? IN_REQ1 : IN_REQ0;
            w_sel_idx   = r_owner;
        end else if (IN_REQ0 && IN_REQ1) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = ~r_last_served;
        end else if (IN_REQ0) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = 1'b0;
        end else if (IN_REQ1) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = 1'b1;
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_lock_nxt        = r_lock;
        w_owner_nxt       = r_owner;
        w_last_served_nxt = r_last_served;
        w_is_last_nxt     = r_is_last;
        w_tmo_nxt         = r_tmo;
        w_tx_data_nxt     = r_tx_data;
        w_tx_send_nxt     = 1'b0;
        w_ack0_nxt        = 1'b0;
        w_ack1_nxt        = 1'b0;
        w_error_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid && IN_TX_READY) begin
                    w_state_nxt   = ST_SEND;
                    w_owner_nxt   = w_sel_idx;
                    w_lock_nxt    = 1'b1;
                    w_tx_data_nxt = w_sel_idx ? IN_DATA1 : IN_DATA0;
                    w_is_last_nxt = w_sel_idx ? IN_LAST1 : IN_LAST0;
                    w_ack0_nxt    = ~w_sel_idx;
                    w_ack1_nxt    = w_sel_idx;
                    w_tmo_nxt     = '0;
                    w_tx_send_nxt = 1'b1;
                end
            end

            ST_SEND: begin
                w_tmo_nxt = r_tmo + TMO_W'(1);
                if (!IN_TX_READY) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_tmo == TMO_LAST) begin
                    // Transmitter never accepted: drop the byte and close the packet.
                    w_state_nxt       = ST_IDLE;
                    w_error_nxt       = 1'b1;
                    w_lock_nxt        = 1'b0;
                    w_last_served_nxt = r_owner;
                end else begin
                    w_tx_send_nxt = 1'b1;
                end
            end

            ST_WAIT_DONE: begin
                if (IN_TX_READY) begin
                    w_state_nxt = ST_IDLE;
                    if (r_is_last) begin
                        w_lock_nxt        = 1'b0;
                        w_last_served_nxt = r_owner;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_grant_nxt = w_lock_nxt ? (w_owner_nxt ? 2'b10 : 2'b01) : 2'b00;
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_lock        <= 1'b0;
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;
            r_is_last     <= 1'b0;
            r_tmo         <= '0;
            r_tx_data     <= '0;
            r_tx_send     <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_grant       <= 2'b00;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lock        <= w_lock_nxt;
            r_owner       <= w_owner_nxt;
            r_last_served <= w_last_served_nxt;
            r_is_last     <= w_is_last_nxt;
            r_tmo         <= w_tmo_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_send     <= w_tx_send_nxt;
            r_ack0        <= w_ack0_nxt;
            r_ack1        <= w_ack1_nxt;
            r_grant       <= w_grant_nxt;
            r_busy        <= w_busy_nxt;
            r_error       <= w_error_nxt;
        end
    end

    assign OUT_ACK0    = r_ack0;
    assign OUT_ACK1    = r_ack1;
    assign OUT_TX_DATA = r_tx_data;
    assign OUT_TX_SEND = r_tx_send;
    assign OUT_GRANT   = r_grant;
    assign OUT_BUSY    = r_busy;
    assign OUT_ERROR   = r_error;

endmodule

// File: tb/tb_tx_arbiter.sv
// Testbench for tx_arbiter: a table of single-cycle selection vectors,
// hand-written multi-cycle sequences (timeout, reset mid-send, READY low),
// and packet streams checked against a packet-level round-robin model.

module tb_tx_arbiter;

    localparam int unsigned TMO = 16;

    logic       CLK;
    logic       RESET;
    logic       IN_REQ0, IN_LAST0, OUT_ACK0;
    logic       IN_REQ1, IN_LAST1, OUT_ACK1;
    logic [7:0] IN_DATA0, IN_DATA1;
    logic [7:0] OUT_TX_DATA;
    logic       OUT_TX_SEND;
    logic       IN_TX_READY;
    logic [1:0] OUT_GRANT;
    logic       OUT_BUSY;
    logic       OUT_ERROR;

    int checks;
    int errors;

    tx_arbiter #(.ACCEPT_TIMEOUT(TMO)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN_REQ0     (IN_REQ0),
        .IN_DATA0    (IN_DATA0),
        .IN_LAST0    (IN_LAST0),
        .OUT_ACK0    (OUT_ACK0),
        .IN_REQ1     (IN_REQ1),
        .IN_DATA1    (IN_DATA1),
        .IN_LAST1    (IN_LAST1),
        .OUT_ACK1    (OUT_ACK1),
        .OUT_TX_DATA (OUT_TX_DATA),
        .OUT_TX_SEND (OUT_TX_SEND),
        .IN_TX_READY (IN_TX_READY),
        .OUT_GRANT   (OUT_GRANT),
        .OUT_BUSY    (OUT_BUSY),
        .OUT_ERROR   (OUT_ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        IN_REQ0 = 1'b0; IN_DATA0 = 8'h00; IN_LAST0 = 1'b0;
        IN_REQ1 = 1'b0; IN_DATA1 = 8'h00; IN_LAST1 = 1'b0;
        IN_TX_READY = 1'b1;
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    // ---------------- selection vector table ----------------
    typedef struct {
        logic       req0;
        logic       req1;
        logic       ready;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       e_ack0;
        logic       e_ack1;
        logic       e_send;
        logic [7:0] e_data;
        logic [1:0] e_grant;
        logic       e_busy;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic r1, input logic rdy,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic ea0, input logic ea1, input logic es,
                                input logic [7:0] ed, input logic [1:0] eg, input logic eb);
        vec_t v;
        v.req0 = r0; v.req1 = r1; v.ready = rdy; v.d0 = d0; v.d1 = d1;
        v.e_ack0 = ea0; v.e_ack1 = ea1; v.e_send = es; v.e_data = ed;
        v.e_grant = eg; v.e_busy = eb;
        return v;
    endfunction

    // ---------------- packet stream engine ----------------
    logic [7:0] q0_d[$];
    logic       q0_l[$];
    logic [7:0] q1_d[$];
    logic       q1_l[$];
    logic [7:0] wire_log[$];
    int         ack_log[$];
    logic [7:0] exp_wire[$];
    int         exp_ack[$];
    logic [1:0] grant_mask;
    int         err_seen;
    int         dual_ack;
    int         busy_no_grant;

    task automatic add_byte(input int who, input logic [7:0] d, input logic last);
        if (who == 0) begin q0_d.push_back(d); q0_l.push_back(last); end
        else          begin q1_d.push_back(d); q1_l.push_back(last); end
    endtask

    task automatic add_packet(input int who, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++)
            add_byte(who, base + 8'(i), (i == len - 1));
    endtask

    // Packet-level model: whole packets alternate between requesters while both
    // have work; requester 0 goes first after reset.
    task automatic build_expected();
        logic [7:0] a_d[$];
        logic       a_l[$];
        logic [7:0] b_d[$];
        logic       b_l[$];
        int         turn;
        a_d = q0_d; a_l = q0_l; b_d = q1_d; b_l = q1_l;
        turn = 0;
        exp_wire.delete();
        exp_ack.delete();
        while (a_d.size() != 0 || b_d.size() != 0) begin
            int         who;
            logic [7:0] d;
            logic       l;
            if (a_d.size() != 0 && b_d.size() != 0) who = turn;
            else if (a_d.size() != 0)                who = 0;
            else                                     who = 1;
            l = 1'b0;
            while (!l && ((who == 0) ? (a_d.size() != 0) : (b_d.size() != 0))) begin
                if (who == 0) begin d = a_d.pop_front(); l = a_l.pop_front(); end
                else          begin d = b_d.pop_front(); l = b_l.pop_front(); end
                exp_wire.push_back(d);
                exp_ack.push_back(who);
            end
            turn = 1 - who;
        end
    endtask

    task automatic drive_reqs();
        IN_REQ0 = (q0_d.size() != 0);
        IN_REQ1 = (q1_d.size() != 0);
        if (IN_REQ0) begin IN_DATA0 = q0_d[0]; IN_LAST0 = q0_l[0]; end
        else         begin IN_DATA0 = 8'h00;   IN_LAST0 = 1'b0;    end
        if (IN_REQ1) begin IN_DATA1 = q1_d[0]; IN_LAST1 = q1_l[0]; end
        else         begin IN_DATA1 = 8'h00;   IN_LAST1 = 1'b0;    end
    endtask

    // Runs requesters and a transmitter model until all queued bytes are sent.
    // busy_fixed=0 selects a random busy time; rand_delay adds accept latency.
    task automatic run_auto(input string tag, input int busy_fixed, input bit rand_delay,
                            input logic [1:0] exp_mask);
        int n;
        int m_busy;
        int m_delay;
        n = 0;
        m_busy = 0;
        m_delay = rand_delay ? int'($urandom_range(0, 4)) : 0;
        wire_log.delete();
        ack_log.delete();
        grant_mask = 2'b00;
        err_seen = 0;
        dual_ack = 0;
        busy_no_grant = 0;
        build_expected();
        drive_reqs();
        while ((q0_d.size() != 0 || q1_d.size() != 0 || OUT_BUSY || !IN_TX_READY) && n < 3000) begin
            tick();
            n++;
            if (OUT_ACK0 && OUT_ACK1) dual_ack++;
            if (OUT_ACK0 && q0_d.size() != 0) begin
                ack_log.push_back(0); void'(q0_d.pop_front()); void'(q0_l.pop_front());
            end
            if (OUT_ACK1 && q1_d.size() != 0) begin
                ack_log.push_back(1); void'(q1_d.pop_front()); void'(q1_l.pop_front());
            end
            if (OUT_ERROR) err_seen++;
            if (OUT_BUSY && OUT_GRANT == 2'b00) busy_no_grant++;
            grant_mask = grant_mask | OUT_GRANT;
            if (!IN_TX_READY) begin
                m_busy--;
                if (m_busy <= 0) IN_TX_READY = 1'b1;
            end else if (OUT_TX_SEND) begin
                if (m_delay > 0) begin
                    m_delay--;
                end else begin
                    wire_log.push_back(OUT_TX_DATA);
                    IN_TX_READY = 1'b0;
                    m_busy  = (busy_fixed > 0) ? busy_fixed : int'($urandom_range(1, 6));
                    m_delay = rand_delay ? int'($urandom_range(0, 4)) : 0;
                end
            end
            drive_reqs();
        end
        chk({tag, "_completed"}, (n < 3000), 1);
        chk({tag, "_wire_len"}, wire_log.size(), exp_wire.size());
        for (int i = 0; i < wire_log.size() && i < exp_wire.size(); i++)
            chk($sformatf("%s_wire[%0d]", tag, i), wire_log[i], exp_wire[i]);
        chk({tag, "_ack_len"}, ack_log.size(), exp_ack.size());
        for (int i = 0; i < ack_log.size() && i < exp_ack.size(); i++)
            chk($sformatf("%s_ack[%0d]", tag, i), ack_log[i], exp_ack[i]);
        chk({tag, "_no_error"}, err_seen, 0);
        chk({tag, "_no_dual_ack"}, dual_ack, 0);
        chk({tag, "_grant_while_busy"}, busy_no_grant, 0);
        chk({tag, "_grant_mask"}, grant_mask, exp_mask);
        chk({tag, "_grant_idle"}, OUT_GRANT, 2'b00);
        q0_d.delete(); q0_l.delete(); q1_d.delete(); q1_l.delete();
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[6];

    initial begin
        int   k;
        logic seen;
        checks = 0;
        errors = 0;
        RESET = 1'b1;

        // Reset defaults
        do_reset();
        tick();
        chk("rst_tx_data", OUT_TX_DATA, 8'h00);
        chk("rst_tx_send", OUT_TX_SEND, 0);
        chk("rst_ack0", OUT_ACK0, 0);
        chk("rst_ack1", OUT_ACK1, 0);
        chk("rst_grant", OUT_GRANT, 2'b00);
        chk("rst_busy", OUT_BUSY, 0);
        chk("rst_error", OUT_ERROR, 0);

        // One-cycle selection decisions from a fresh reset
        vecs[0] = mk(0, 0, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00, 2'b00, 0);
        vecs[1] = mk(1, 0, 1, 8'h12, 8'h22, 1, 0, 1, 8'h12, 2'b01, 1);
        vecs[2] = mk(0, 1, 1, 8'h11, 8'h3C, 0, 1, 1, 8'h3C, 2'b10, 1);
        vecs[3] = mk(1, 1, 1, 8'hA5, 8'h5A, 1, 0, 1, 8'hA5, 2'b01, 1);
        vecs[4] = mk(1, 0, 0, 8'h13, 8'h22, 0, 0, 0, 8'h00, 2'b00, 0);
        vecs[5] = mk(1, 1, 0, 8'h14, 8'h24, 0, 0, 0, 8'h00, 2'b00, 0);
        for (int i = 0; i < 6; i++) begin
            do_reset();
            IN_REQ0 = vecs[i].req0; IN_DATA0 = vecs[i].d0; IN_LAST0 = 1'b1;
            IN_REQ1 = vecs[i].req1; IN_DATA1 = vecs[i].d1; IN_LAST1 = 1'b1;
            IN_TX_READY = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d_ack0", i), OUT_ACK0, vecs[i].e_ack0);
            chk($sformatf("vec%0d_ack1", i), OUT_ACK1, vecs[i].e_ack1);
            chk($sformatf("vec%0d_send", i), OUT_TX_SEND, vecs[i].e_send);
            chk($sformatf("vec%0d_data", i), OUT_TX_DATA, vecs[i].e_data);
            chk($sformatf("vec%0d_grant", i), OUT_GRANT, vecs[i].e_grant);
            chk($sformatf("vec%0d_busy", i), OUT_BUSY, vecs[i].e_busy);
        end

        // Single packet, transmitter busy 5 cycles per byte
        do_reset();
        add_byte(0, 8'h48, 1'b0);
        add_byte(0, 8'h49, 1'b1);
        run_auto("single", 5, 1'b0, 2'b01);

        // Contention and lock, then requester 0 wins the next round
        do_reset();
        add_packet(0, 3, 8'hA0);
        add_packet(1, 3, 8'hB0);
        add_packet(0, 1, 8'hC0);
        add_packet(1, 1, 8'hD0);
        run_auto("contend", 2, 1'b0, 2'b11);

        // Randomized packet streams
        for (int r = 0; r < 4; r++) begin
            int         n0;
            int         n1;
            logic [1:0] m;
            do_reset();
            n0 = int'($urandom_range(0, 3));
            n1 = int'($urandom_range(0, 3));
            if (n0 == 0 && n1 == 0) n0 = 1;
            for (int p = 0; p < n0; p++) add_packet(0, int'($urandom_range(1, 4)), 8'($urandom));
            for (int p = 0; p < n1; p++) add_packet(1, int'($urandom_range(1, 4)), 8'($urandom));
            m = {(n1 != 0), (n0 != 0)};
            run_auto($sformatf("rand%0d", r), 0, 1'b1, m);
        end

        // Timeout abort, then pending requester 0 is granted
        do_reset();
        IN_REQ1 = 1'b1; IN_DATA1 = 8'h55; IN_LAST1 = 1'b1;
        tick();
        chk("to_ack1", OUT_ACK1, 1);
        chk("to_send", OUT_TX_SEND, 1);
        IN_REQ1 = 1'b0;
        IN_REQ0 = 1'b1; IN_DATA0 = 8'h66; IN_LAST0 = 1'b1;
        k = 0;
        while (!OUT_ERROR && k < 40) begin
            tick();
            k++;
        end
        chk("to_cycles", k, TMO);
        chk("to_send_fall", OUT_TX_SEND, 0);
        chk("to_grant_rel", OUT_GRANT, 2'b00);
        tick();
        chk("to_next_ack0", OUT_ACK0, 1);
        chk("to_next_data", OUT_TX_DATA, 8'h66);
        chk("to_next_grant", OUT_GRANT, 2'b01);
        chk("to_error_pulse", OUT_ERROR, 0);

        // Reset during SEND
        do_reset();
        IN_REQ0 = 1'b1; IN_DATA0 = 8'h33; IN_LAST0 = 1'b1;
        tick();
        chk("rms_ack0", OUT_ACK0, 1);
        IN_REQ0 = 1'b0;
        tick();
        chk("rms_in_send", OUT_TX_SEND, 1);
        RESET = 1'b1;
        tick();
        chk("rms_send", OUT_TX_SEND, 0);
        chk("rms_grant", OUT_GRANT, 2'b00);
        chk("rms_busy", OUT_BUSY, 0);
        chk("rms_data", OUT_TX_DATA, 8'h00);
        RESET = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen = seen | OUT_ACK0 | OUT_ACK1;
        end
        chk("rms_no_reack", seen, 0);

        // READY low in IDLE blocks selection
        do_reset();
        IN_TX_READY = 1'b0;
        IN_REQ0 = 1'b1; IN_DATA0 = 8'h77; IN_LAST0 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rdy_low_ack0_%0d", c), OUT_ACK0, 0);
        end
        IN_TX_READY = 1'b1;
        tick();
        chk("rdy_rise_ack0", OUT_ACK0, 1);
        chk("rdy_rise_data", OUT_TX_DATA, 8'h77);
        IN_REQ0 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
